// File: rtl/hpi_pkg.sv
// Shared definitions for the EZ-OTG HPI responder: register selects,
// STATUS bit positions and the DATA auto-increment step.
package hpi_pkg;

  typedef enum logic [1:0] {
    HPI_DATA    = 2'd0,
    HPI_MAILBOX = 2'd1,
    HPI_ADDRESS = 2'd2,
    HPI_STATUS  = 2'd3
  } hpi_reg_e;

  localparam int unsigned ST_MBX_OUT = 0;
  localparam int unsigned ST_OVF     = 8;

  // ADDRESS holds a byte address; each DATA access moves one 16-bit word.
  localparam logic [15:0] ADDR_INC = 16'd2;

  function automatic logic [15:0] status_word(input logic ovf, input logic mbx_out_full);
    logic [15:0] s;
    s             = '0;
    s[ST_OVF]     = ovf;
    s[ST_MBX_OUT] = mbx_out_full;
    return s;
  endfunction

endpackage

// File: rtl/hpi_ram.sv
// Single-port synchronous word RAM backing the HPI DATA register.
// Read data is registered and only changes on an enabled read.
module hpi_ram #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned ADDR_W    = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/otg_hpi_responder.sv
// Device-side EZ-OTG HPI responder: strobe edge detection, register decode,
// host/device mailboxes and the registered read path.
module otg_hpi_responder
  import hpi_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned ADDR_W    = 12
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        otg_hpi_cs_n,
  input  logic [1:0]  otg_hpi_address,
  input  logic        otg_hpi_r_n,
  input  logic        otg_hpi_w_n,
  input  logic [15:0] otg_hpi_wdata,
  output logic [15:0] otg_hpi_rdata,
  output logic        hpi_int,
  output logic [15:0] dev_mbx_in_data,
  output logic        dev_mbx_in_valid,
  input  logic        dev_mbx_in_ack,
  input  logic [15:0] dev_mbx_out_data,
  input  logic        dev_mbx_out_we
);

  hpi_reg_e          reg_sel;
  logic              rd_act, wr_act;
  logic              rd_act_q, wr_act_q;
  logic              rd_rise, wr_rise;
  logic              data_sel, mbx_sel, addr_sel, stat_sel;
  logic [15:0]       addr_q;
  logic [15:0]       mbx_out_q;
  logic              ovf_q;
  logic [15:0]       rd_snap;
  logic [15:0]       rd_hold_q;
  logic              rd_pend_q;
  logic              rd_ram_q;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_idx;
  logic [15:0]       ram_rdata;

  always_comb begin
    reg_sel  = hpi_reg_e'(otg_hpi_address);
    rd_act   = !otg_hpi_cs_n && !otg_hpi_r_n &&  otg_hpi_w_n;
    wr_act   = !otg_hpi_cs_n && !otg_hpi_w_n &&  otg_hpi_r_n;
    rd_rise  = rd_act && !rd_act_q;
    wr_rise  = wr_act && !wr_act_q;
    data_sel = (reg_sel == HPI_DATA);
    mbx_sel  = (reg_sel == HPI_MAILBOX);
    addr_sel = (reg_sel == HPI_ADDRESS);
    stat_sel = (reg_sel == HPI_STATUS);
    ram_idx  = addr_q[ADDR_W:1];
    ram_en   = (rd_rise || wr_rise) && data_sel;
    ram_we   = wr_rise;
  end

  // Snapshot of non-RAM registers taken in the strobe cycle, so a same-cycle
  // device mailbox load does not leak into the value the host sees.
  always_comb begin
    rd_snap = '0;
    unique case (reg_sel)
      HPI_MAILBOX: rd_snap = mbx_out_q;
      HPI_ADDRESS: rd_snap = addr_q;
      HPI_STATUS:  rd_snap = status_word(ovf_q, hpi_int);
      default:     rd_snap = '0;
    endcase
  end

  // Detectors reset to "active" so a strobe held through reset is ignored.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rd_act_q <= 1'b1;
      wr_act_q <= 1'b1;
    end else begin
      rd_act_q <= rd_act;
      wr_act_q <= wr_act;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      addr_q <= '0;
    end else if (wr_rise && addr_sel) begin
      addr_q <= otg_hpi_wdata;
    end else if ((rd_rise || wr_rise) && data_sel) begin
      addr_q <= addr_q + ADDR_INC;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rd_pend_q     <= 1'b0;
      rd_ram_q      <= 1'b0;
      rd_hold_q     <= '0;
      otg_hpi_rdata <= '0;
    end else begin
      rd_pend_q <= rd_rise;
      if (rd_rise) begin
        rd_ram_q  <= data_sel;
        rd_hold_q <= rd_snap;
      end
      if (rd_pend_q) begin
        otg_hpi_rdata <= rd_ram_q ? ram_rdata : rd_hold_q;
      end
    end
  end

  // Device-to-host mailbox: a device load beats a same-cycle host read.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      mbx_out_q <= '0;
      hpi_int   <= 1'b0;
    end else if (dev_mbx_out_we) begin
      mbx_out_q <= dev_mbx_out_data;
      hpi_int   <= 1'b1;
    end else if (rd_rise && mbx_sel) begin
      hpi_int   <= 1'b0;
    end
  end

  // Host-to-device mailbox: a host write beats a same-cycle ack, and an
  // ack in that cycle means the old word was consumed, so no overflow.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      dev_mbx_in_data  <= '0;
      dev_mbx_in_valid <= 1'b0;
      ovf_q            <= 1'b0;
    end else begin
      if (wr_rise && mbx_sel) begin
        dev_mbx_in_data  <= otg_hpi_wdata;
        dev_mbx_in_valid <= 1'b1;
        if (dev_mbx_in_valid && !dev_mbx_in_ack) begin
          ovf_q <= 1'b1;
        end
      end else if (dev_mbx_in_ack) begin
        dev_mbx_in_valid <= 1'b0;
      end
      if (wr_rise && stat_sel) begin
        ovf_q <= 1'b0;
      end
    end
  end

  hpi_ram #(
    .MEM_WORDS (MEM_WORDS),
    .ADDR_W    (ADDR_W)
  ) u_ram (
    .clk   (clk_clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_idx),
    .wdata (otg_hpi_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_otg_hpi_responder.sv
// Scoreboard bench for otg_hpi_responder: directed scenarios plus random
// host/device traffic checked against a behavioural register/RAM model.
module tb_otg_hpi_responder;

  localparam logic [1:0] A_DATA = 2'd0, A_MBX = 2'd1, A_ADDR = 2'd2, A_STAT = 2'd3;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        otg_hpi_cs_n = 1'b1;
  logic [1:0]  otg_hpi_address = 2'd0;
  logic        otg_hpi_r_n = 1'b1;
  logic        otg_hpi_w_n = 1'b1;
  logic [15:0] otg_hpi_wdata = '0;
  logic [15:0] otg_hpi_rdata;
  logic        hpi_int;
  logic [15:0] dev_mbx_in_data;
  logic        dev_mbx_in_valid;
  logic        dev_mbx_in_ack = 1'b0;
  logic [15:0] dev_mbx_out_data = '0;
  logic        dev_mbx_out_we = 1'b0;

  otg_hpi_responder #(.MEM_WORDS(4096), .ADDR_W(12)) dut (
    .clk_clk          (clk_clk),
    .reset_reset_n    (reset_reset_n),
    .otg_hpi_cs_n     (otg_hpi_cs_n),
    .otg_hpi_address  (otg_hpi_address),
    .otg_hpi_r_n      (otg_hpi_r_n),
    .otg_hpi_w_n      (otg_hpi_w_n),
    .otg_hpi_wdata    (otg_hpi_wdata),
    .otg_hpi_rdata    (otg_hpi_rdata),
    .hpi_int          (hpi_int),
    .dev_mbx_in_data  (dev_mbx_in_data),
    .dev_mbx_in_valid (dev_mbx_in_valid),
    .dev_mbx_in_ack   (dev_mbx_in_ack),
    .dev_mbx_out_data (dev_mbx_out_data),
    .dev_mbx_out_we   (dev_mbx_out_we)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {
    string       name;
    logic [15:0] val;
    bit          care;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          rst_epoch = 0;

  // Behavioural model state
  logic [15:0] m_mem [4096];
  bit          m_wr  [4096];
  logic [15:0] m_addr, m_out, m_in_data, m_last;
  bit          m_int, m_in_valid, m_ovf, m_last_ok;

  always @(negedge reset_reset_n) rst_epoch++;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_addr = '0; m_out = '0; m_in_data = '0; m_last = '0;
    m_int = 0; m_in_valid = 0; m_ovf = 0; m_last_ok = 1;
  endtask

  function automatic int unsigned m_idx();
    return (int'(m_addr) / 2) % 4096;
  endfunction

  task automatic push(input string nm, input logic [15:0] v, input bit care);
    exp_t e;
    e.name = nm; e.val = v; e.care = care;
    sb.push_back(e);
    m_last = v; m_last_ok = care;
  endtask

  // One host access; optional device mailbox load / ack in the strobe's first cycle.
  task automatic access(input bit is_wr, input logic [1:0] a, input logic [15:0] d,
                        input int hold, input bit dwe, input logic [15:0] dd, input bit ack);
    int unsigned i;
    i = m_idx();
    if (is_wr) begin
      case (a)
        A_DATA: begin m_mem[i] = d; m_wr[i] = 1; m_addr += 16'd2; end
        A_MBX:  begin if (m_in_valid && !ack) m_ovf = 1; m_in_data = d; m_in_valid = 1; end
        A_ADDR: m_addr = d;
        default: m_ovf = 0;
      endcase
    end else begin
      case (a)
        A_DATA: begin push("rd_data", m_mem[i], m_wr[i]); m_addr += 16'd2; end
        A_MBX:  begin push("rd_mbx", m_out, 1); m_int = 0; end
        A_ADDR: push("rd_addr", m_addr, 1);
        default: push("rd_status", {7'b0, m_ovf, 7'b0, m_int}, 1);
      endcase
    end
    if (dwe) begin m_out = dd; m_int = 1; end
    if (ack && !(is_wr && a == A_MBX)) m_in_valid = 0;

    @(posedge clk_clk); #1;
    otg_hpi_cs_n = 1'b0; otg_hpi_address = a; otg_hpi_wdata = d;
    otg_hpi_r_n = is_wr; otg_hpi_w_n = !is_wr;
    dev_mbx_out_we = dwe; dev_mbx_out_data = dd; dev_mbx_in_ack = ack;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk_clk); #1;
      dev_mbx_out_we = 1'b0; dev_mbx_in_ack = 1'b0;
    end
    otg_hpi_cs_n = 1'b1; otg_hpi_r_n = 1'b1; otg_hpi_w_n = 1'b1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    access(1, a, d, 1, 0, 16'h0, 0);
  endtask

  task automatic rd(input logic [1:0] a);
    access(0, a, 16'h0, 1, 0, 16'h0, 0);
  endtask

  task automatic dev_load(input logic [15:0] d);
    m_out = d; m_int = 1;
    @(posedge clk_clk); #1; dev_mbx_out_we = 1'b1; dev_mbx_out_data = d;
    @(posedge clk_clk); #1; dev_mbx_out_we = 1'b0;
  endtask

  task automatic dev_ack();
    m_in_valid = 0;
    @(posedge clk_clk); #1; dev_mbx_in_ack = 1'b1;
    @(posedge clk_clk); #1; dev_mbx_in_ack = 1'b0;
  endtask

  task automatic illegal(input logic [1:0] a, input int hold);
    @(posedge clk_clk); #1;
    otg_hpi_cs_n = 1'b0; otg_hpi_address = a; otg_hpi_wdata = 16'($urandom);
    otg_hpi_r_n = 1'b0; otg_hpi_w_n = 1'b0;
    repeat (hold) @(posedge clk_clk);
    #1; otg_hpi_cs_n = 1'b1; otg_hpi_r_n = 1'b1; otg_hpi_w_n = 1'b1;
    @(negedge clk_clk);
    if (m_last_ok) chk("rdata_hold_illegal", otg_hpi_rdata, m_last);
  endtask

  task automatic side_chk();
    @(negedge clk_clk);
    chk("mbx_in_valid", {15'b0, dev_mbx_in_valid}, {15'b0, m_in_valid});
    chk("mbx_in_data", dev_mbx_in_data, m_in_data);
    chk("hpi_int", {15'b0, hpi_int}, {15'b0, m_int});
  endtask

  // Monitor: observes read strobes on the bus and checks rdata one cycle after.
  initial begin : monitor
    bit   prev;
    bit   cur;
    int   ep;
    exp_t e;
    prev = 1;
    forever begin
      @(posedge clk_clk);
      cur = !otg_hpi_cs_n && !otg_hpi_r_n && otg_hpi_w_n;
      if (reset_reset_n && cur && !prev) begin
        ep = rst_epoch;
        @(posedge clk_clk);
        cur  = !otg_hpi_cs_n && !otg_hpi_r_n && otg_hpi_w_n;
        prev = reset_reset_n ? cur : 1'b1;
        @(negedge clk_clk);
        if (ep == rst_epoch && reset_reset_n) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_unexpected: got %h required no read", otg_hpi_rdata);
          end else begin
            e = sb.pop_front();
            if (e.care) chk(e.name, otg_hpi_rdata, e.val);
          end
        end
      end else begin
        prev = reset_reset_n ? cur : 1'b1;
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: got timeout required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [15:0] v;
    int          op;
    for (int i = 0; i < 4096; i++) m_wr[i] = 0;
    model_reset();
    repeat (3) @(posedge clk_clk);
    @(negedge clk_clk);
    chk("rst_rdata", otg_hpi_rdata, 16'h0);
    side_chk();
    @(posedge clk_clk); #1; reset_reset_n = 1'b1;
    rd(A_STAT); rd(A_ADDR);

    // DATA auto-increment
    wr(A_ADDR, 16'h1000);
    wr(A_DATA, 16'hAAAA); wr(A_DATA, 16'hBBBB); wr(A_DATA, 16'hCCCC);
    wr(A_ADDR, 16'h1000);
    rd(A_DATA); rd(A_DATA); rd(A_DATA); rd(A_ADDR);

    // Address wrap and aliasing
    wr(A_ADDR, 16'hFFFE); wr(A_DATA, 16'h1234); rd(A_ADDR);
    wr(A_ADDR, 16'h1FFE); wr(A_DATA, 16'h7777);
    wr(A_ADDR, 16'hFFFE); rd(A_DATA); rd(A_ADDR);

    // Host-to-device mailbox, overflow, ack
    wr(A_MBX, 16'h5A5A); side_chk();
    wr(A_MBX, 16'h0001); side_chk(); rd(A_STAT);
    wr(A_STAT, 16'hFFFF); rd(A_STAT);
    dev_ack(); side_chk();
    wr(A_MBX, 16'h3333); access(1, A_MBX, 16'h4444, 1, 0, 16'h0, 1); side_chk(); rd(A_STAT);

    // Device-to-host mailbox, same-cycle load vs host read
    dev_load(16'hBEEF); side_chk(); rd(A_STAT);
    rd(A_MBX); side_chk();
    dev_load(16'h1111);
    access(0, A_MBX, 16'h0, 1, 1, 16'h2222, 0); side_chk();
    rd(A_MBX); side_chk();

    // Long strobe, illegal strobes
    wr(A_ADDR, 16'h1000);
    access(0, A_DATA, 16'h0, 10, 0, 16'h0, 0); rd(A_ADDR);
    illegal(A_DATA, 3); illegal(A_MBX, 2); illegal(A_ADDR, 2);
    side_chk(); rd(A_ADDR); rd(A_DATA);

    // Reset during a DATA read, strobe held through release
    wr(A_ADDR, 16'h0040); dev_load(16'h9999); wr(A_MBX, 16'h8888); rd(A_ADDR);
    repeat (3) @(posedge clk_clk);
    #1; otg_hpi_cs_n = 1'b0; otg_hpi_address = A_DATA; otg_hpi_r_n = 1'b0;
    @(posedge clk_clk); #2; reset_reset_n = 1'b0; #1;
    model_reset();
    chk("rst_mid_rdata", otg_hpi_rdata, 16'h0);
    chk("rst_mid_int", {15'b0, hpi_int}, 16'h0);
    chk("rst_mid_valid", {15'b0, dev_mbx_in_valid}, 16'h0);
    repeat (3) @(posedge clk_clk);
    #1; reset_reset_n = 1'b1;
    repeat (4) @(posedge clk_clk);
    #1; otg_hpi_r_n = 1'b1; otg_hpi_cs_n = 1'b1;
    side_chk(); rd(A_ADDR); rd(A_STAT); rd(A_MBX);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 12);
      v  = 16'($urandom);
      case (op)
        0: wr(A_ADDR, (v & 16'hE000) | 16'($urandom_range(0, 31) * 2) | (v & 16'h0001));
        1, 2: access(1, A_DATA, v, $urandom_range(1, 3), 0, 16'h0, 0);
        3, 4: access(0, A_DATA, 16'h0, $urandom_range(1, 3), 0, 16'h0, 0);
        5: rd(A_ADDR);
        6: access(1, A_MBX, v, $urandom_range(1, 2), 0, 16'h0, ($urandom_range(0, 3) == 0));
        7: access(0, A_MBX, 16'h0, $urandom_range(1, 2), ($urandom_range(0, 3) == 0), 16'($urandom), 0);
        8: rd(A_STAT);
        9: wr(A_STAT, v);
        10: dev_load(v);
        11: dev_ack();
        default: illegal(2'($urandom_range(0, 3)), $urandom_range(1, 3));
      endcase
      if (n % 4 == 0) side_chk();
    end

    repeat (4) @(posedge clk_clk);
    chk("sb_drain", 16'(sb.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/otg_hpi_responder.md
Name: otg_hpi_responder

Overview:
- Synthesizable device-side model of the EZ-OTG Host Port Interface (HPI): the responder to the otg_hpi_* PIO strobes driven by the Nios system.
- Decodes chip-select, read and write strobes against four HPI registers: DATA, MAILBOX, ADDRESS and STATUS.
- Backs DATA with internal word RAM that auto-increments its address on every access.
- Used in simulation and on-chip loopback so that USB keyboard/HPI firmware can be exercised without the physical controller.

Parameters:
- MEM_WORDS, 4096, number of 16-bit words in the backing RAM; must be a power of 2.
- ADDR_W, 12, log2(MEM_WORDS); RAM word-index width.

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- otg_hpi_cs_n  in  1  chip select, active low.
- otg_hpi_address  in  2  register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS.
- otg_hpi_r_n  in  1  read strobe, active low.
- otg_hpi_w_n  in  1  write strobe, active low.
- otg_hpi_wdata  in  16  host write data (driven from host data_out).
- otg_hpi_rdata  out  16  read data returned to the host (host data_in).
- hpi_int  out  1  high while the device-to-host mailbox is full.
- dev_mbx_in_data  out  16  last host-written mailbox word.
- dev_mbx_in_valid  out  1  host mailbox word pending.
- dev_mbx_in_ack  in  1  device-side pulse that consumes the pending word.
- dev_mbx_out_data  in  16  device-to-host mailbox word.
- dev_mbx_out_we  in  1  device-side pulse that loads dev_mbx_out_data.

Behaviour:
- Reset values (asynchronous, all zero): otg_hpi_rdata=0, hpi_int=0, dev_mbx_in_valid=0, dev_mbx_in_data=0, address register=0, mailbox-out register=0, overflow flag=0. RAM contents are not reset.
- Access detection:
  - rd_act = !cs_n & !r_n & w_n; wr_act = !cs_n & !w_n & r_n.
  - Registered copies of rd_act and wr_act give rising-edge detection. Exactly one access is performed per strobe assertion, regardless of strobe length.
  - Both strobes low with cs_n low is illegal: no state change, and rdata holds its value.
- Read:
  - On the rd_act rising edge (cycle N), otg_hpi_rdata is updated at the clock edge ending cycle N+1 (1-cycle latency).
  - otg_hpi_rdata holds that value until the next read.
- Write:
  - Data is sampled on the wr_act rising-edge cycle.
  - The effect (register or RAM update) is visible on the following cycle.
- ADDRESS register (16-bit byte address): a write loads it; a read returns it. RAM word index = addr[ADDR_W:1]; upper bits are ignored (alias). Bit 0 is ignored.
- DATA register:
  - Read returns RAM[index]; write stores to RAM[index].
  - After either access, addr <= addr + 2, mod 2^16; 0xFFFE wraps to 0x0000.
  - Back-to-back DATA accesses must see the incremented address.
- MAILBOX register:
  - Host write: dev_mbx_in_data <= wdata and dev_mbx_in_valid <= 1. If valid was already 1, the word is overwritten and the overflow flag is set (sticky).
  - Host read: returns mailbox-out and clears hpi_int.
  - dev_mbx_out_we: loads mailbox-out and sets hpi_int.
  - Same-cycle dev_mbx_out_we and host mailbox read: the host gets the old value and hpi_int stays 1 (the load wins).
  - dev_mbx_in_ack clears dev_mbx_in_valid. Same-cycle host mailbox write and ack: valid stays 1 (the write wins) and no overflow is recorded.
- STATUS register:
  - Read returns {7'b0, overflow, 7'b0, hpi_int}, i.e. bit0 = mailbox-out full, bit8 = overflow.
  - A write of any value clears overflow only.
- Reset asserted mid-access: everything returns to reset values immediately. A strobe still low at reset release does not trigger an access; the edge detector resets to "active" so that only a fresh assertion counts.

Decomposition:
- Shared package hpi_pkg: register-select constants (HPI_DATA=2'd0, HPI_MAILBOX=2'd1, HPI_ADDRESS=2'd2, HPI_STATUS=2'd3), status bit positions (ST_MBX_OUT=0, ST_OVF=8), address increment constant 2.
- One sub-module: hpi_ram, a single-port synchronous RAM (MEM_WORDS x 16, 1-cycle read) so that synthesis infers M9K blocks.
- Top level contains strobe edge detection, register decode, mailbox logic and the read mux.

Test Plan:
- Write ADDRESS=0x1000, then DATA writes 0xAAAA, 0xBBBB, 0xCCCC; write ADDRESS=0x1000 and do three DATA reads -> returns 0xAAAA, 0xBBBB, 0xCCCC; ADDRESS read returns 0x1006.
- Write ADDRESS=0xFFFE, DATA write 0x1234 -> ADDRESS reads 0x0000. With MEM_WORDS=4096, ADDRESS=0x1FFE aliases to index 0xFFF.
- Host writes MAILBOX=0x5A5A -> dev_mbx_in_valid=1, data=0x5A5A. Second write 0x0001 before ack -> data=0x0001 and STATUS bit8=1. STATUS write -> bit8=0. Ack -> valid=0.
- dev_mbx_out_we with 0xBEEF -> hpi_int=1 and STATUS reads 0x0001. MAILBOX read returns 0xBEEF and hpi_int=0 the next cycle. Repeat with dev write in the same cycle as the host read -> host gets the old value and hpi_int remains 1.
- Hold r_n low for 10 cycles on DATA -> exactly one address increment (+2). Assert r_n and w_n together -> no RAM, address or mailbox change.
- Assert reset_reset_n low mid DATA read -> rdata=0 and address=0 asynchronously. Release with r_n still low -> no increment until the strobe deasserts and reasserts.
